// File: rtl/ti_sbox_share_refresh_pkg.sv
// ti_sbox_share_refresh_pkg
// Shared constants, share/randomness vector types and the ring-refresh helper
// for the TI S-box output stage. Vectors are MSB-first: element [0] of a share
// is its most significant bit, and r0 occupies rnd[0:SW-1].
package ti_sbox_share_refresh_pkg;

    localparam int SW     = 6;   // share width (S-box width)
    localparam int NSBOX  = 32;  // S-box outputs per layer
    localparam int NSHARE = 4;   // output shares per S-box

    typedef logic [0:SW-1]        share_t;
    typedef logic [0:NSHARE*SW-1] rnd_t;

    // Ring refresh of share i: t_i = s_i ^ r_i ^ r_((i+1) mod NSHARE).
    // Every r_j enters exactly two shares, so the XOR of all shares is kept.
    function automatic share_t ring_refresh(input share_t s, input rnd_t r, input int i);
        int j;
        j = (i + 1) % NSHARE;
        return s ^ r[i*SW +: SW] ^ r[j*SW +: SW];
    endfunction

endpackage

// File: rtl/ti_share_skid2.sv
// ti_share_skid2
// Generic 2-entry valid/ready buffer with a registered ready.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     upstream handshake, transfer when both high
//   in_data  [W-1:0]      data written on transfer
//   out_valid/out_ready   downstream handshake, transfer when both high
//   out_data [W-1:0]      head entry, always driven from a register
// Handshake: a beat moves when valid && ready in the same cycle; valid never
// depends on ready, and in_ready depends on the occupancy register only, so
// there is no combinational path from out_ready to in_ready.
module ti_share_skid2
    import ti_sbox_share_refresh_pkg::*;
#(
    parameter int W = NSHARE * SW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic [1:0]   r_count;
    logic         w_push;
    logic         w_pop;

    assign in_ready  = (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_head;

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    // An empty buffer writes straight to the head so the
                    // result is visible on the very next cycle.
                    if (r_count == 2'd0) r_head <= in_data;
                    else                 r_tail <= in_data;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Only reachable with one entry held: the head leaves
                    // and the new beat replaces it, occupancy unchanged.
                    r_head <= in_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ti_sbox_share_refresh.sv
// ti_sbox_share_refresh
// Remasks the four output shares of one TI S-box with fresh randomness (ring
// refresh), registers them as a glitch barrier in a 2-entry skid buffer and
// tags each result with its S-box position in the layer.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   in_valid/in_ready      upstream handshake
//   in_s0..in_s3 [0:SW-1]  unrefreshed output shares
//   rnd [0:4*SW-1]         r0..r3, r0 in the first slice; used only on accept
//   out_valid/out_ready    downstream handshake
//   out_s0..out_s3         refreshed shares of the head result
//   out_idx [IDXW-1:0]     S-box position of the head result
//   out_last               head result is the final S-box of the layer
module ti_sbox_share_refresh #(
    parameter int SW    = ti_sbox_share_refresh_pkg::SW,
    parameter int NSBOX = ti_sbox_share_refresh_pkg::NSBOX,
    parameter int IDXW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [0:SW-1]   in_s0,
    input  logic [0:SW-1]   in_s1,
    input  logic [0:SW-1]   in_s2,
    input  logic [0:SW-1]   in_s3,
    input  logic [0:4*SW-1] rnd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [0:SW-1]   out_s0,
    output logic [0:SW-1]   out_s1,
    output logic [0:SW-1]   out_s2,
    output logic [0:SW-1]   out_s3,
    output logic [IDXW-1:0] out_idx,
    output logic            out_last
);
    import ti_sbox_share_refresh_pkg::*;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSBOX - 1);

    share_t          w_t0;
    share_t          w_t1;
    share_t          w_t2;
    share_t          w_t3;
    logic [4*SW-1:0] w_in_data;
    logic [4*SW-1:0] w_out_data;
    logic            w_out_valid;
    logic            w_pop;
    logic [IDXW-1:0] r_idx;

    // Refreshed shares only feed the entry registers of the buffer.
    assign w_t0 = ring_refresh(in_s0, rnd, 0);
    assign w_t1 = ring_refresh(in_s1, rnd, 1);
    assign w_t2 = ring_refresh(in_s2, rnd, 2);
    assign w_t3 = ring_refresh(in_s3, rnd, 3);
    assign w_in_data = {w_t0, w_t1, w_t2, w_t3};

    ti_share_skid2 #(
        .W(4 * SW)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (w_in_data),
        .out_valid(w_out_valid),
        .out_ready(out_ready),
        .out_data (w_out_data)
    );

    assign out_valid = w_out_valid;
    assign out_s0    = w_out_data[4*SW-1 -: SW];
    assign out_s1    = w_out_data[3*SW-1 -: SW];
    assign out_s2    = w_out_data[2*SW-1 -: SW];
    assign out_s3    = w_out_data[SW-1   -: SW];

    assign w_pop = w_out_valid && out_ready;

    // Position of the head result: advances per pop, wraps at the layer end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
        end else if (w_pop) begin
            r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
        end
    end

    assign out_idx  = r_idx;
    assign out_last = w_out_valid && (r_idx == LAST_IDX);

endmodule

// File: tb/tb_ti_sbox_share_refresh.sv
// tb_ti_sbox_share_refresh
// Self-checking bench: table of single-result vectors, hand-written
// backpressure / streaming / wrap / reset sequences and a randomised run,
// all cross-checked by a scoreboard fed at accept time and drained at pop time.
module tb_ti_sbox_share_refresh;

    localparam int SW    = 6;
    localparam int NSBOX = 32;
    localparam int IDXW  = 5;
    localparam int W     = 4 * SW;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [0:SW-1]   in_s0, in_s1, in_s2, in_s3;
    logic [0:W-1]    rnd;
    logic            out_valid;
    logic            out_ready;
    logic [0:SW-1]   out_s0, out_s1, out_s2, out_s3;
    logic [IDXW-1:0] out_idx;
    logic            out_last;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_pop  = 0;
    int n_last = 0;
    int exp_idx = 0;

    logic [W-1:0]  exp_q[$];
    logic [SW-1:0] xor_q[$];

    typedef struct {
        logic [SW-1:0] s0, s1, s2, s3;
        logic [W-1:0]  r;
        logic [W-1:0]  exp;
    } vec_t;

    vec_t vecs[5];

    ti_sbox_share_refresh #(.SW(SW), .NSBOX(NSBOX), .IDXW(IDXW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_s0    (in_s0),
        .in_s1    (in_s1),
        .in_s2    (in_s2),
        .in_s3    (in_s3),
        .rnd      (rnd),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_s0   (out_s0),
        .out_s1   (out_s1),
        .out_s2   (out_s2),
        .out_s3   (out_s3),
        .out_idx  (out_idx),
        .out_last (out_last)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // r_i taken numerically: r0 is the most significant 6 bits of rnd.
    function automatic logic [SW-1:0] rpart(input logic [W-1:0] r, input int i);
        return SW'(r >> ((3 - i) * SW));
    endfunction

    function automatic logic [W-1:0] model(input logic [SW-1:0] s0, input logic [SW-1:0] s1,
                                           input logic [SW-1:0] s2, input logic [SW-1:0] s3,
                                           input logic [W-1:0] r);
        logic [SW-1:0] t0, t1, t2, t3;
        t0 = s0 ^ rpart(r, 0) ^ rpart(r, 1);
        t1 = s1 ^ rpart(r, 1) ^ rpart(r, 2);
        t2 = s2 ^ rpart(r, 2) ^ rpart(r, 3);
        t3 = s3 ^ rpart(r, 3) ^ rpart(r, 0);
        return {t0, t1, t2, t3};
    endfunction

    function automatic logic [W-1:0] head_data();
        return {out_s0, out_s1, out_s2, out_s3};
    endfunction

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        in_s0 = SW'($urandom_range(0, 63));
        in_s1 = SW'($urandom_range(0, 63));
        in_s2 = SW'($urandom_range(0, 63));
        in_s3 = SW'($urandom_range(0, 63));
        rnd   = W'($urandom_range(0, (1 << W) - 1));
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
    endtask

    // ---------------- scoreboard ----------------
    logic [W-1:0]  mon_exp;
    logic [SW-1:0] mon_xor;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            xor_q.delete();
            exp_idx = 0;
        end else begin
            if (out_valid && out_ready) begin
                check("pop_has_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_exp = exp_q.pop_front();
                    mon_xor = xor_q.pop_front();
                    check("sb_data", 32'(head_data()), 32'(mon_exp));
                    check("sb_xor", 32'(out_s0 ^ out_s1 ^ out_s2 ^ out_s3), 32'(mon_xor));
                end
                check("sb_idx", 32'(out_idx), 32'(exp_idx));
                check("sb_last", 32'(out_last), 32'(exp_idx == NSBOX - 1));
                if (out_last) n_last++;
                exp_idx = (exp_idx + 1) % NSBOX;
                n_pop++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_s0, in_s1, in_s2, in_s3, rnd));
                xor_q.push_back(in_s0 ^ in_s1 ^ in_s2 ^ in_s3);
            end
        end
    end

    // ---------------- test sequence ----------------
    logic [W-1:0] e1, e2, e3;
    int p0, accepted, cyc;

    initial begin
        vecs[0] = '{s0: 6'h3F, s1: 6'h00, s2: 6'h15, s3: 6'h2A, r: 24'hFFF000, exp: {6'h3F, 6'h3F, 6'h15, 6'h15}};
        vecs[1] = '{s0: 6'h00, s1: 6'h00, s2: 6'h00, s3: 6'h00, r: 24'h000000, exp: {6'h00, 6'h00, 6'h00, 6'h00}};
        vecs[2] = '{s0: 6'h00, s1: 6'h00, s2: 6'h00, s3: 6'h00, r: 24'hFC0000, exp: {6'h3F, 6'h00, 6'h00, 6'h3F}};
        vecs[3] = '{s0: 6'h01, s1: 6'h02, s2: 6'h04, s3: 6'h08, r: 24'h041041, exp: {6'h01, 6'h02, 6'h04, 6'h08}};
        vecs[4] = '{s0: 6'h12, s1: 6'h34, s2: 6'h0B, s3: 6'h2D, r: 24'h123456, exp: {6'h35, 6'h06, 6'h0C, 6'h3F}};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_s0 = '0; in_s1 = '0; in_s2 = '0; in_s3 = '0;
        rnd = '0;
        repeat (3) step();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_idx", 32'(out_idx), 32'd0);
        check("rst_out_data", 32'(head_data()), 32'd0);
        rst = 1'b0;
        step();

        // Table: one result at a time, visible the cycle after accept.
        for (int i = 0; i < 5; i++) begin
            in_s0 = vecs[i].s0; in_s1 = vecs[i].s1; in_s2 = vecs[i].s2; in_s3 = vecs[i].s3;
            rnd = vecs[i].r;
            in_valid = 1'b1;
            out_ready = 1'b1;
            step();
            in_valid = 1'b0;
            check("vec_valid", 32'(out_valid), 32'd1);
            check("vec_data", 32'(head_data()), 32'(vecs[i].exp));
            check("vec_xor", 32'(out_s0 ^ out_s1 ^ out_s2 ^ out_s3),
                  32'(vecs[i].s0 ^ vecs[i].s1 ^ vecs[i].s2 ^ vecs[i].s3));
            check("vec_idx", 32'(out_idx), 32'(i));
            step();
            check("vec_drained", 32'(out_valid), 32'd0);
        end

        // Backpressure: three pushes with the consumer stalled.
        out_ready = 1'b0;
        in_valid = 1'b1;
        rand_inputs();
        e1 = model(in_s0, in_s1, in_s2, in_s3, rnd);
        step();
        check("bp_ready_after_1", 32'(in_ready), 32'd1);
        check("bp_head_1", 32'(head_data()), 32'(e1));
        rand_inputs();
        e2 = model(in_s0, in_s1, in_s2, in_s3, rnd);
        step();
        check("bp_ready_after_2", 32'(in_ready), 32'd0);
        check("bp_head_2", 32'(head_data()), 32'(e1));
        rand_inputs();
        e3 = model(in_s0, in_s1, in_s2, in_s3, rnd);
        for (int k = 0; k < 3; k++) begin
            step();
            check("bp_full_ready", 32'(in_ready), 32'd0);
            check("bp_full_valid", 32'(out_valid), 32'd1);
            check("bp_full_head", 32'(head_data()), 32'(e1));
        end
        out_ready = 1'b1;
        step();
        check("bp_release_head", 32'(head_data()), 32'(e2));
        check("bp_release_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("bp_third_head", 32'(head_data()), 32'(e3));
        step();
        check("bp_empty", 32'(out_valid), 32'd0);

        // Streaming: one entry held, push and pop together every cycle.
        out_ready = 1'b0;
        in_valid = 1'b1;
        rand_inputs();
        step();
        out_ready = 1'b1;
        p0 = n_pop;
        for (int k = 0; k < 10; k++) begin
            rand_inputs();
            step();
            check("st_in_ready", 32'(in_ready), 32'd1);
            check("st_out_valid", 32'(out_valid), 32'd1);
        end
        check("st_pops", 32'(n_pop - p0), 32'd10);
        in_valid = 1'b0;
        step();

        // Layer wrap: 33 results from a fresh index.
        do_reset();
        n_last = 0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 33; k++) begin
            rand_inputs();
            step();
        end
        in_valid = 1'b0;
        step();
        check("wrap_last_count", 32'(n_last), 32'd1);
        check("wrap_idx_after", 32'(out_idx), 32'd1);

        // Mid-operation reset with two entries held and idx 17.
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 17; k++) begin
            rand_inputs();
            step();
        end
        in_valid = 1'b0;
        step();
        check("mr_idx17", 32'(out_idx), 32'd17);
        out_ready = 1'b0;
        in_valid = 1'b1;
        rand_inputs();
        step();
        rand_inputs();
        step();
        in_valid = 1'b0;
        check("mr_full", 32'(in_ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("mr_out_valid", 32'(out_valid), 32'd0);
        check("mr_out_last", 32'(out_last), 32'd0);
        check("mr_in_ready", 32'(in_ready), 32'd1);
        check("mr_idx_now", 32'(out_idx), 32'd0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        step();
        out_ready = 1'b1;
        in_valid = 1'b1;
        rand_inputs();
        step();
        in_valid = 1'b0;
        check("mr_post_valid", 32'(out_valid), 32'd1);
        check("mr_post_idx", 32'(out_idx), 32'd0);
        step();

        // Randomised traffic with random backpressure.
        accepted = 0;
        cyc = 0;
        while (accepted < 1000 && cyc < 20000) begin
            rand_inputs();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if (in_valid && in_ready) accepted++;
            step();
            cyc++;
        end
        check("rand_accepted", 32'(accepted), 32'd1000);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        check("rand_drained_valid", 32'(out_valid), 32'd0);
        check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
